// File: rtl/lap_recall_hold_if.sv
// Lap/recall stage bus: live digits and buttons in, display digits and status out.
// master drives the counter/button side, slave is the lap_recall_hold block.
interface lap_recall_hold_if;
    logic       lap_pulse;
    logic       recall_pulse;
    logic       clear_pulse;
    logic       running;
    logic [3:0] live_min;
    logic [3:0] live_st;
    logic [3:0] live_su;
    logic [3:0] live_ten;
    logic [3:0] disp_min;
    logic [3:0] disp_st;
    logic [3:0] disp_su;
    logic [3:0] disp_ten;
    logic       hold_active;
    logic       recall_mode;
    logic [1:0] lap_index;
    logic [2:0] lap_count;

    modport master (
        output lap_pulse, recall_pulse, clear_pulse, running,
        output live_min, live_st, live_su, live_ten,
        input  disp_min, disp_st, disp_su, disp_ten,
        input  hold_active, recall_mode, lap_index, lap_count
    );

    modport slave (
        input  lap_pulse, recall_pulse, clear_pulse, running,
        input  live_min, live_st, live_su, live_ten,
        output disp_min, disp_st, disp_su, disp_ten,
        output hold_active, recall_mode, lap_index, lap_count
    );
endinterface

// File: rtl/lap_recall_hold.sv
// Lap/split capture between stopwatch counter and display mux: live pass-through,
// timed split hold, four-entry circular lap buffer and timed recall browsing.
module lap_recall_hold #(
    parameter int HOLD_CYCLES = 300_000_000,
    parameter int TIMER_W     = 29
) (
    input logic         clock,
    input logic         reset_n,
    lap_recall_hold_if.slave bus
);
    typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_t;

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(HOLD_CYCLES - 1);

    state_t             state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [1:0]         wr_ptr, wr_ptr_n;
    logic [1:0]         idx_n, rd_ptr;
    logic [2:0]         count_n;
    logic [15:0]        live, disp_n, hold_reg;
    logic [3:0][15:0]   buffer;
    logic               capture, lap_ok;

    assign live   = {bus.live_min, bus.live_st, bus.live_su, bus.live_ten};
    assign lap_ok = bus.lap_pulse & bus.running;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= LIVE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        wr_ptr_n = wr_ptr;
        count_n = bus.lap_count;
        idx_n   = bus.lap_index;
        capture = 1'b0;

        if (bus.clear_pulse) begin
            state_n  = LIVE;
            count_n  = 3'd0;
            wr_ptr_n = 2'd0;
            idx_n    = 2'd0;
            timer_n  = '0;
        end else begin
            unique case (state)
                LIVE: begin
                    if (lap_ok) begin
                        capture = 1'b1;
                    end else if (bus.recall_pulse && bus.lap_count != 3'd0) begin
                        state_n = RECALL;
                        idx_n   = 2'd0;
                        timer_n = RELOAD;
                    end
                end
                HOLD: begin
                    if (lap_ok) begin
                        capture = 1'b1;
                    end else if (bus.recall_pulse) begin
                        state_n = RECALL;
                        idx_n   = 2'd0;
                        timer_n = RELOAD;
                    end else if (timer == '0) begin
                        state_n = LIVE;
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                RECALL: begin
                    // A lap press while browsing just returns to the live view.
                    if (bus.lap_pulse) begin
                        state_n = LIVE;
                        timer_n = '0;
                    end else if (bus.recall_pulse) begin
                        idx_n   = ({1'b0, bus.lap_index} == bus.lap_count - 3'd1) ?
                                  2'd0 : bus.lap_index + 2'd1;
                        timer_n = RELOAD;
                    end else if (timer == '0) begin
                        state_n = LIVE;
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                default: state_n = LIVE;
            endcase
        end

        if (capture) begin
            state_n  = HOLD;
            timer_n  = RELOAD;
            wr_ptr_n = wr_ptr + 2'd1;
            count_n  = (bus.lap_count == 3'd4) ? 3'd4 : bus.lap_count + 3'd1;
        end

        if (state_n != RECALL) idx_n = 2'd0;

        // Newest entry sits just behind the write pointer.
        rd_ptr = wr_ptr_n - 2'd1 - idx_n;

        unique case (state_n)
            HOLD:    disp_n = capture ? live : hold_reg;
            RECALL:  disp_n = buffer[rd_ptr];
            default: disp_n = live;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timer           <= '0;
            wr_ptr          <= 2'd0;
            hold_reg        <= 16'd0;
            buffer          <= '0;
            bus.disp_min    <= 4'd0;
            bus.disp_st     <= 4'd0;
            bus.disp_su     <= 4'd0;
            bus.disp_ten    <= 4'd0;
            bus.hold_active <= 1'b0;
            bus.recall_mode <= 1'b0;
            bus.lap_index   <= 2'd0;
            bus.lap_count   <= 3'd0;
        end else begin
            timer  <= timer_n;
            wr_ptr <= wr_ptr_n;
            if (capture) begin
                hold_reg       <= live;
                buffer[wr_ptr] <= live;
            end
            {bus.disp_min, bus.disp_st, bus.disp_su, bus.disp_ten} <= disp_n;
            bus.hold_active <= (state_n == HOLD);
            bus.recall_mode <= (state_n == RECALL);
            bus.lap_index   <= idx_n;
            bus.lap_count   <= count_n;
        end
    end
endmodule

// File: tb/tb_lap_recall_hold.sv
// Scenario bench for lap_recall_hold: a queue-of-laps reference model predicts
// each cycle's outputs into a scoreboard that is popped after the clock edge.
module tb_lap_recall_hold;
    localparam int H  = 8;
    localparam int TW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lap_recall_hold_if bus();

    lap_recall_hold #(.HOLD_CYCLES(H), .TIMER_W(TW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0] disp;
        logic        hold;
        logic        rec;
        logic [1:0]  idx;
        logic [2:0]  cnt;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        lap;
        logic        rec;
        logic        clr;
        logic        run;
        logic [15:0] live;
    } stim_t;

    out_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: 0 LIVE, 1 HOLD, 2 RECALL; laps[0] is the newest
    int          m_state = 0;
    int          m_timer = 0;
    int          m_idx = 0;
    logic [15:0] m_hold = 16'd0;
    logic [15:0] laps[$];

    function automatic stim_t mk(logic rst, logic lap, logic rec, logic clr,
                                 logic run, logic [15:0] live);
        stim_t s;
        s.rst = rst; s.lap = lap; s.rec = rec; s.clr = clr; s.run = run; s.live = live;
        return s;
    endfunction

    function automatic logic [15:0] bcd(int v);
        logic [15:0] r;
        r = {4'(v % 10), 4'((v / 10) % 6), 4'((v / 3) % 10), 4'((v / 7) % 10)};
        return r;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.disp = {bus.disp_min, bus.disp_st, bus.disp_su, bus.disp_ten};
        o.hold = bus.hold_active;
        o.rec  = bus.recall_mode;
        o.idx  = bus.lap_index;
        o.cnt  = bus.lap_count;
        return o;
    endfunction

    function automatic void predict(stim_t s);
        out_t e;
        logic cap;
        cap = 1'b0;
        e = '0;
        if (!s.rst) begin
            m_state = 0; m_timer = 0; m_idx = 0; m_hold = 16'd0;
            laps.delete();
        end else begin
            if (s.clr) begin
                m_state = 0; m_timer = 0; m_idx = 0;
                laps.delete();
            end else if (m_state == 0) begin
                if (s.lap && s.run) cap = 1'b1;
                else if (s.rec && laps.size() > 0) begin
                    m_state = 2; m_idx = 0; m_timer = H - 1;
                end
            end else if (m_state == 1) begin
                if (s.lap && s.run) cap = 1'b1;
                else if (s.rec) begin
                    m_state = 2; m_idx = 0; m_timer = H - 1;
                end else if (m_timer == 0) m_state = 0;
                else m_timer--;
            end else begin
                if (s.lap) begin
                    m_state = 0; m_timer = 0;
                end else if (s.rec) begin
                    m_idx = (m_idx + 1 == laps.size()) ? 0 : m_idx + 1;
                    m_timer = H - 1;
                end else if (m_timer == 0) m_state = 0;
                else m_timer--;
            end
            if (cap) begin
                laps.push_front(s.live);
                if (laps.size() > 4) void'(laps.pop_back());
                m_hold = s.live; m_state = 1; m_timer = H - 1;
            end
            if (m_state != 2) m_idx = 0;
            e.disp = (m_state == 0) ? s.live : (m_state == 1) ? m_hold : laps[m_idx];
            e.hold = (m_state == 1);
            e.rec  = (m_state == 2);
            e.idx  = 2'(m_idx);
            e.cnt  = 3'(laps.size());
        end
        sb.push_back(e);
    endfunction

    task automatic drive(stim_t s);
        reset_n          = s.rst;
        bus.lap_pulse    = s.lap;
        bus.recall_pulse = s.rec;
        bus.clear_pulse  = s.clr;
        bus.running      = s.run;
        {bus.live_min, bus.live_st, bus.live_su, bus.live_ten} = s.live;
        predict(s);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        out_t got, exp;
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234));
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp || got !== '0) begin
                miscompares++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_passthrough();
        out_t got, exp;
        for (int i = 0; i < 6; i++) begin
            drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (i == 0) ? 16'h1234 : bcd(i * 13)));
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL passthrough cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_lap_hold();
        out_t got, exp;
        int hold_cycles;
        hold_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            drive(mk(1'b1, i == 0, 1'b0, 1'b0, 1'b1, (i == 0) ? 16'h0157 : bcd(i * 11 + 3)));
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got.hold) hold_cycles++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL lap_hold cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
        vectors++;
        if (hold_cycles != H) begin
            miscompares++;
            $display("FAIL hold_length got=%0d exp=%0d", hold_cycles, H);
        end
    endtask

    task automatic test_overwrite_recall();
        out_t  got, exp;
        stim_t st[$];
        logic [15:0] lapv[5];
        lapv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000));
        for (int k = 0; k < 5; k++) begin
            st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, lapv[k]));
            st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bcd(k + 40)));
        end
        for (int k = 0; k < 10; k++) st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bcd(k + 50)));
        for (int k = 0; k < 5; k++) begin
            st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, bcd(k + 60)));
            st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bcd(k + 70)));
        end
        for (int k = 0; k < 10; k++) st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bcd(k + 80)));
        foreach (st[i]) begin
            drive(st[i]);
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL overwrite_recall cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_ignored();
        out_t  got, exp;
        stim_t st[$];
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0909));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0910));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0911));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0912));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0913));
        foreach (st[i]) begin
            drive(st[i]);
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ignored cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        out_t  got, exp;
        stim_t st[$];
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2345));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2346));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2347));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2348));
        st.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2349));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2350));
        foreach (st[i]) begin
            drive(st[i]);
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL simultaneous cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_recall();
        out_t  got, exp;
        stim_t st[$];
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3456));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3457));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3458));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3459));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3500));
        foreach (st[i]) begin
            drive(st[i]);
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_recall cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t  got, exp;
        stim_t s;
        // lap during recall exits without capture, then random pulse traffic
        drive(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4001));
        void'(sb.pop_front());
        drive(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4002));
        void'(sb.pop_front());
        for (int i = 0; i < 400; i++) begin
            if (i == 0) s = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4003);
            else s = mk(1'b1, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                        $urandom_range(0, 60) == 0, $urandom_range(0, 7) != 0,
                        bcd(int'($urandom_range(0, 599))));
            drive(s);
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        bus.lap_pulse = 1'b0;
        bus.recall_pulse = 1'b0;
        bus.clear_pulse = 1'b0;
        bus.running = 1'b0;
        {bus.live_min, bus.live_st, bus.live_su, bus.live_ten} = 16'h0;
        test_reset();
        test_passthrough();
        test_lap_hold();
        test_overwrite_recall();
        test_ignored();
        test_simultaneous();
        test_reset_mid_recall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
